// File: rtl/maxmin_pkg.sv
// Shared types and helpers for the max/min group reducer.
package maxmin_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RD    = 2'b01,
      S_WR    = 2'b10,
      S_RETRY = 2'b11
   } state_t;

   localparam logic MODE_MAX = 1'b0;
   localparam logic MODE_MIN = 1'b1;

   // Minimum result of 1 keeps single-bit fields legal for tiny parameters.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(n)) r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/maxmin_sync.sv
// Registered reconfiguration acknowledge; only granted while the reducer is idle.
module maxmin_sync (
   input  logic clk,
   input  logic rst,
   input  logic is_idle,
   input  logic rc_reqn,
   output logic rc_ackn
);

   logic r_ackn;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ackn <= 1'b1;
      end else if (rc_reqn) begin
         r_ackn <= 1'b1;
      end else if (is_idle) begin
         r_ackn <= 1'b0;
      end
   end

   assign rc_ackn = r_ackn;

endmodule

// File: rtl/maxmin_reduce.sv
// Reduces each group of C_NUM words to its maximum or minimum plus the winning position,
// with downstream retry, upstream timeout flag and an idle-only reconfiguration handshake.
module maxmin_reduce
   import maxmin_pkg::*;
#(
   parameter int C_DW          = 32,
   parameter int C_NUM         = 4,
   parameter int C_SIGNED      = 0,
   parameter int C_RETRY_DELAY = 16,
   parameter int C_TO_LIMIT    = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic                     c_prdy,
   output logic                     c_crdy,
   output logic                     c_cerr,
   input  logic [C_DW-1:0]          c_data,
   output logic                     p_prdy,
   input  logic                     p_crdy,
   input  logic                     p_cerr,
   output logic [C_DW-1:0]          p_data,
   output logic [clog2(C_NUM)-1:0]  p_idx,
   input  logic                     rc_reqn,
   output logic                     rc_ackn
);

   localparam int W_IDX = clog2(C_NUM);
   localparam int W_TO  = clog2(C_TO_LIMIT + 1);
   localparam int W_RTY = clog2(C_RETRY_DELAY + 1);

   state_t            r_state;
   state_t            w_next;
   logic              r_mode;
   logic [C_DW-1:0]   r_acc;
   logic [W_IDX-1:0]  r_idx;
   logic [W_IDX-1:0]  r_pos;
   logic [W_TO-1:0]   r_to;
   logic [W_RTY-1:0]  r_rty;

   logic w_accept;
   logic w_last;
   logic w_go;
   logic w_gt;
   logic w_lt;
   logic w_better;
   logic w_is_idle;

   assign w_is_idle = (r_state == S_IDLE);
   assign w_accept  = c_prdy & c_crdy;
   assign w_last    = w_accept & (r_pos == W_IDX'(C_NUM - 1));
   // rc_reqn low in idle means an acknowledge is being granted this cycle.
   assign w_go      = c_prdy & rc_ackn & rc_reqn;

   always_comb begin
      w_gt = 1'b0;
      w_lt = 1'b0;
      if (C_SIGNED != 0) begin
         w_gt = $signed(c_data) > $signed(r_acc);
         w_lt = $signed(c_data) < $signed(r_acc);
      end else begin
         w_gt = c_data > r_acc;
         w_lt = c_data < r_acc;
      end
   end

   assign w_better = (r_mode == MODE_MIN) ? w_lt : w_gt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_next = S_RD;
         S_RD:    if (w_last) w_next = S_WR;
         S_WR: begin
            if (p_crdy) begin
               w_next = S_IDLE;
            end else if (p_cerr) begin
               w_next = S_RETRY;
            end
         end
         S_RETRY: if (r_rty == W_RTY'(C_RETRY_DELAY - 1)) w_next = S_WR;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode <= MODE_MAX;
         r_acc  <= '0;
         r_idx  <= '0;
         r_pos  <= '0;
      end else begin
         if (w_is_idle && w_go) begin
            r_mode <= mode;
            r_pos  <= '0;
         end
         if (w_accept) begin
            r_pos <= w_last ? '0 : r_pos + 1'b1;
            if ((r_pos == '0) || w_better) begin
               r_acc <= c_data;
               r_idx <= r_pos;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rty <= '0;
         r_to  <= '0;
      end else begin
         r_rty <= (r_state == S_RETRY) ? r_rty + 1'b1 : '0;
         if (c_prdy && !c_crdy) begin
            if (r_to != W_TO'(C_TO_LIMIT)) r_to <= r_to + 1'b1;
         end else begin
            r_to <= '0;
         end
      end
   end

   maxmin_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .is_idle (w_is_idle),
      .rc_reqn (rc_reqn),
      .rc_ackn (rc_ackn)
   );

   assign c_crdy = (r_state == S_RD);
   assign p_prdy = (r_state == S_WR);
   assign c_cerr = (r_to == W_TO'(C_TO_LIMIT)) & ~c_crdy;
   assign p_data = r_acc;
   assign p_idx  = r_idx;

endmodule

// File: tb/tb_maxmin_reduce.sv
// Randomised self-checking bench: an unsigned and a signed reducer share stimulus and are
// compared against an extremum-then-first-position reference.
module tb_maxmin_reduce;

   typedef logic [31:0] grp_t [4];

   localparam int RETRY = 16;
   localparam int TO_LIM = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic        c_prdy;
   logic [31:0] c_data;
   logic        p_crdy;
   logic        p_cerr;
   logic        rc_reqn;

   logic        c_crdy_u, c_cerr_u, p_prdy_u, rc_ackn_u;
   logic [31:0] p_data_u;
   logic [1:0]  p_idx_u;
   logic        c_crdy_s, c_cerr_s, p_prdy_s, rc_ackn_s;
   logic [31:0] p_data_s;
   logic [1:0]  p_idx_s;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] eu_d, es_d;
   logic [1:0]  eu_i, es_i;

   always #5 clk = ~clk;

   maxmin_reduce #(.C_DW(32), .C_NUM(4), .C_SIGNED(0), .C_RETRY_DELAY(RETRY),
                   .C_TO_LIMIT(TO_LIM)) u_dut_u (
      .clk(clk), .rst(rst), .mode(mode), .c_prdy(c_prdy), .c_crdy(c_crdy_u),
      .c_cerr(c_cerr_u), .c_data(c_data), .p_prdy(p_prdy_u), .p_crdy(p_crdy),
      .p_cerr(p_cerr), .p_data(p_data_u), .p_idx(p_idx_u), .rc_reqn(rc_reqn),
      .rc_ackn(rc_ackn_u)
   );

   maxmin_reduce #(.C_DW(32), .C_NUM(4), .C_SIGNED(1), .C_RETRY_DELAY(RETRY),
                   .C_TO_LIMIT(TO_LIM)) u_dut_s (
      .clk(clk), .rst(rst), .mode(mode), .c_prdy(c_prdy), .c_crdy(c_crdy_s),
      .c_cerr(c_cerr_s), .c_data(c_data), .p_prdy(p_prdy_s), .p_crdy(p_crdy),
      .p_cerr(p_cerr), .p_data(p_data_s), .p_idx(p_idx_s), .rc_reqn(rc_reqn),
      .rc_ackn(rc_ackn_s)
   );

   // Extremum over the whole group, then the lowest position holding that value.
   function automatic void ref_reduce(input grp_t w, input logic md, input bit sg,
                                      output logic [31:0] d, output logic [1:0] ix);
      longint v [4];
      longint best;
      for (int i = 0; i < 4; i++) v[i] = sg ? longint'($signed(w[i])) : longint'(w[i]);
      best = v[0];
      for (int i = 1; i < 4; i++) begin
         if (md == 1'b0 && v[i] > best) best = v[i];
         if (md == 1'b1 && v[i] < best) best = v[i];
      end
      ix = 2'd0;
      for (int i = 3; i >= 0; i--) if (v[i] == best) ix = 2'(i);
      d = w[ix];
   endfunction

   function automatic void model(input grp_t w, input logic md);
      ref_reduce(w, md, 1'b0, eu_d, eu_i);
      ref_reduce(w, md, 1'b1, es_d, es_i);
   endfunction

   task automatic drive(input grp_t w, input int first, input int last, input logic md,
                        input bit gaps);
      int guard;
      mode = md;
      for (int k = first; k <= last; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            c_prdy = 1'b0;
            @(negedge clk);
         end
         c_data = w[k];
         c_prdy = 1'b1;
         guard = 0;
         while (c_crdy_u !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
         end
         n_checks++;
         if (guard >= 40) begin
            n_fail++;
            $display("FAIL drive_wait word %0d: c_crdy=%b required 1", k, c_crdy_u);
         end
         @(negedge clk);
         if (k == 0) mode = ~md; // mode must already be latched for the group
      end
      c_prdy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      c_prdy = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({c_crdy_u, c_cerr_u, p_prdy_u, rc_ackn_u} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_ctrl: crdy,cerr,prdy,ackn=%b required 0001",
                  {c_crdy_u, c_cerr_u, p_prdy_u, rc_ackn_u});
      end
      n_checks++;
      if (p_data_u !== 32'd0 || p_idx_u !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_data: p_data=%h p_idx=%0d required 0/0", p_data_u, p_idx_u);
      end
      c_prdy = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_max();
      grp_t w;
      w = '{32'd5, 32'd9, 32'd9, 32'd2};
      model(w, 1'b0);
      drive(w, 0, 3, 1'b0, 1'b0);
      n_checks++;
      if (p_prdy_u !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_latency: p_prdy=%b required 1", p_prdy_u);
      end
      n_checks++;
      if (p_data_u !== 32'd9 || p_idx_u !== 2'd1) begin
         n_fail++;
         $display("FAIL basic_u: p_data=%h p_idx=%0d required 9/1", p_data_u, p_idx_u);
      end
      n_checks++;
      if (p_data_s !== es_d || p_idx_s !== es_i) begin
         n_fail++;
         $display("FAIL basic_s: p_data=%h p_idx=%0d required %h/%0d",
                  p_data_s, p_idx_s, es_d, es_i);
      end
      p_crdy = 1'b1;
      @(negedge clk);
      p_crdy = 1'b0;
      n_checks++;
      if (p_prdy_u !== 1'b0 || c_crdy_u !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_bubble: p_prdy=%b c_crdy=%b required 0/0", p_prdy_u, c_crdy_u);
      end
   endtask

   task automatic test_signed_min();
      grp_t w;
      w = '{32'd3, 32'hFFFF_FFFE, 32'd7, 32'd0};
      model(w, 1'b1);
      drive(w, 0, 3, 1'b1, 1'b0);
      n_checks++;
      if (p_data_s !== 32'hFFFF_FFFE || p_idx_s !== 2'd1) begin
         n_fail++;
         $display("FAIL signed_min_s: p_data=%h p_idx=%0d required fffffffe/1",
                  p_data_s, p_idx_s);
      end
      n_checks++;
      if (p_data_u !== eu_d || p_idx_u !== eu_i) begin
         n_fail++;
         $display("FAIL signed_min_u: p_data=%h p_idx=%0d required %h/%0d",
                  p_data_u, p_idx_u, eu_d, eu_i);
      end
      p_crdy = 1'b1;
      @(negedge clk);
      p_crdy = 1'b0;
   endtask

   task automatic test_retry();
      grp_t w;
      int cnt;
      int highs;
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      model(w, 1'b0);
      drive(w, 0, 3, 1'b0, 1'b0);
      p_cerr = 1'b1;
      @(negedge clk);
      p_cerr = 1'b0;
      cnt = 0;
      while (p_prdy_u === 1'b0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      n_checks++;
      if (cnt != RETRY) begin
         n_fail++;
         $display("FAIL retry_gap: p_prdy low %0d cycles required %0d", cnt, RETRY);
      end
      n_checks++;
      if (p_data_u !== eu_d || p_idx_u !== eu_i || p_data_s !== es_d || p_idx_s !== es_i) begin
         n_fail++;
         $display("FAIL retry_hold: u=%h/%0d s=%h/%0d required %h/%0d %h/%0d",
                  p_data_u, p_idx_u, p_data_s, p_idx_s, eu_d, eu_i, es_d, es_i);
      end
      // Accept and error together: accept must win, so no retry resurfaces.
      p_crdy = 1'b1;
      p_cerr = 1'b1;
      @(negedge clk);
      p_crdy = 1'b0;
      p_cerr = 1'b0;
      highs = 0;
      repeat (20) begin
         if (p_prdy_u !== 1'b0) highs++;
         @(negedge clk);
      end
      n_checks++;
      if (highs != 0) begin
         n_fail++;
         $display("FAIL crdy_priority: p_prdy high %0d cycles required 0", highs);
      end
   endtask

   task automatic test_timeout();
      grp_t w;
      grp_t w2;
      logic md2;
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         w2[i] = $urandom;
      end
      md2 = 1'($urandom_range(0, 1));
      drive(w, 0, 3, 1'b0, 1'b0);
      mode = md2;
      c_data = w2[0];
      c_prdy = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         n_checks++;
         if (c_cerr_u !== ((j - 1) >= TO_LIM)) begin
            n_fail++;
            $display("FAIL timeout_stall%0d: c_cerr=%b required %b", j, c_cerr_u,
                     ((j - 1) >= TO_LIM));
         end
         @(negedge clk);
      end
      p_crdy = 1'b1;
      @(negedge clk);
      p_crdy = 1'b0;
      n_checks++;
      if (c_cerr_u !== 1'b1 || c_crdy_u !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_idle: c_cerr=%b c_crdy=%b required 1/0", c_cerr_u, c_crdy_u);
      end
      @(negedge clk);
      n_checks++;
      if (c_cerr_u !== 1'b0 || c_crdy_u !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_clear: c_cerr=%b c_crdy=%b required 0/1", c_cerr_u, c_crdy_u);
      end
      model(w2, md2);
      drive(w2, 0, 3, md2, 1'b0);
      n_checks++;
      if (p_data_u !== eu_d || p_idx_u !== eu_i || p_data_s !== es_d || p_idx_s !== es_i) begin
         n_fail++;
         $display("FAIL timeout_group: u=%h/%0d s=%h/%0d required %h/%0d %h/%0d",
                  p_data_u, p_idx_u, p_data_s, p_idx_s, eu_d, eu_i, es_d, es_i);
      end
      p_crdy = 1'b1;
      @(negedge clk);
      p_crdy = 1'b0;
   endtask

   task automatic test_reconfig();
      grp_t w;
      grp_t w2;
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         w2[i] = $urandom;
      end
      drive(w, 0, 1, 1'b0, 1'b0);
      rc_reqn = 1'b0;
      drive(w, 2, 3, 1'b0, 1'b0);
      repeat (3) begin
         n_checks++;
         if (rc_ackn_u !== 1'b1 || p_prdy_u !== 1'b1) begin
            n_fail++;
            $display("FAIL rc_busy: rc_ackn=%b p_prdy=%b required 1/1", rc_ackn_u, p_prdy_u);
         end
         @(negedge clk);
      end
      c_data = w2[0];
      c_prdy = 1'b1;
      p_crdy = 1'b1;
      @(negedge clk);
      p_crdy = 1'b0;
      n_checks++;
      if (rc_ackn_u !== 1'b1 || c_crdy_u !== 1'b0) begin
         n_fail++;
         $display("FAIL rc_idle0: rc_ackn=%b c_crdy=%b required 1/0", rc_ackn_u, c_crdy_u);
      end
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (rc_ackn_u !== 1'b0 || c_crdy_u !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_held: rc_ackn=%b c_crdy=%b required 0/0", rc_ackn_u, c_crdy_u);
         end
      end
      rc_reqn = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rc_ackn_u !== 1'b1 || c_crdy_u !== 1'b0) begin
         n_fail++;
         $display("FAIL rc_release: rc_ackn=%b c_crdy=%b required 1/0", rc_ackn_u, c_crdy_u);
      end
      @(negedge clk);
      n_checks++;
      if (c_crdy_u !== 1'b1) begin
         n_fail++;
         $display("FAIL rc_resume: c_crdy=%b required 1", c_crdy_u);
      end
      model(w2, 1'b0);
      drive(w2, 0, 3, 1'b0, 1'b0);
      n_checks++;
      if (p_data_u !== eu_d || p_idx_u !== eu_i) begin
         n_fail++;
         $display("FAIL rc_group: p_data=%h p_idx=%0d required %h/%0d",
                  p_data_u, p_idx_u, eu_d, eu_i);
      end
      p_crdy = 1'b1;
      @(negedge clk);
      p_crdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      grp_t w;
      int highs;
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      drive(w, 0, 2, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({c_crdy_u, c_cerr_u, p_prdy_u, rc_ackn_u} !== 4'b0001 || p_data_u !== 32'd0 ||
          p_idx_u !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid: crdy,cerr,prdy,ackn=%b data=%h idx=%0d required 0001/0/0",
                  {c_crdy_u, c_cerr_u, p_prdy_u, rc_ackn_u}, p_data_u, p_idx_u);
      end
      @(negedge clk);
      rst = 1'b0;
      highs = 0;
      repeat (20) begin
         @(negedge clk);
         if (p_prdy_u !== 1'b0 || c_crdy_u !== 1'b0) highs++;
      end
      n_checks++;
      if (highs != 0) begin
         n_fail++;
         $display("FAIL reset_discard: active %0d cycles required 0", highs);
      end
      w = '{32'd1, 32'd2, 32'd3, 32'd4};
      drive(w, 0, 3, 1'b0, 1'b0);
      n_checks++;
      if (p_data_u !== 32'd4 || p_idx_u !== 2'd3 || p_data_s !== 32'd4 || p_idx_s !== 2'd3) begin
         n_fail++;
         $display("FAIL reset_regroup: u=%h/%0d s=%h/%0d required 4/3",
                  p_data_u, p_idx_u, p_data_s, p_idx_s);
      end
      p_crdy = 1'b1;
      @(negedge clk);
      p_crdy = 1'b0;
   endtask

   task automatic test_random();
      grp_t w;
      logic md;
      int hold;
      int bad;
      for (int g = 0; g < 40; g++) begin
         for (int i = 0; i < 4; i++) begin
            w[i] = (g % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (g % 5 == 1) w[i] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         end
         md = 1'($urandom_range(0, 1));
         model(w, md);
         drive(w, 0, 3, md, 1'b1);
         hold = $urandom_range(0, 3);
         bad = 0;
         for (int h = 0; h <= hold; h++) begin
            if (p_prdy_u !== 1'b1 || p_data_u !== eu_d || p_idx_u !== eu_i ||
                p_data_s !== es_d || p_idx_s !== es_i) bad++;
            if (h < hold) @(negedge clk);
         end
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL random_g%0d: u=%h/%0d s=%h/%0d prdy=%b required %h/%0d %h/%0d",
                     g, p_data_u, p_idx_u, p_data_s, p_idx_s, p_prdy_u, eu_d, eu_i, es_d, es_i);
         end
         p_crdy = 1'b1;
         @(negedge clk);
         p_crdy = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mode = 1'b0;
      c_prdy = 1'b0;
      c_data = 32'd0;
      p_crdy = 1'b0;
      p_cerr = 1'b0;
      rc_reqn = 1'b1;
      test_reset();
      test_basic_max();
      test_signed_min();
      test_retry();
      test_timeout();
      test_reconfig();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
